// File: rtl/timer_scheduler.sv
// Round-robin software timers sharing one hardware tick and one decrementer.
// Config is served only between scans; ticks always win over config.
module timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NUM_CH-1:0] irq_clr,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] active,
  output logic              irq,
  output logic              overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NCH  = (CH_W + 1)'(NUM_CH);

  state_t            state;
  logic [CH_W-1:0]   idx;
  logic              tick_pend;
  logic              s1, s2, s2_d;
  logic              tick_evt;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  period [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic              ch_ok;
  logic              cfg_fire;
  logic              svc_hit;
  logic [NUM_CH-1:0] pend_nxt;

  assign tick_evt  = s2 & ~s2_d;
  assign cfg_ready = (state == IDLE) & ~tick_evt & ~tick_pend;
  assign ch_ok     = {1'b0, cfg_ch} < NCH;
  assign cfg_fire  = cfg_valid & cfg_ready & ch_ok;
  assign svc_hit   = (state == SCAN) & active[idx] & (cnt[idx] == '0);

  // An expiry on the same edge as irq_clr keeps the flag set.
  always_comb begin
    pend_nxt = pending & ~irq_clr;
    if (cfg_fire && cfg_start)
      pend_nxt[cfg_ch] = 1'b0;
    if (svc_hit)
      pend_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tick_pend <= 1'b0;
      overrun   <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s2_d      <= 1'b0;
      expired   <= '0;
      pending   <= '0;
      active    <= '0;
      irq       <= 1'b0;
      mode      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        period[i] <= '0;
      end
    end else begin
      s1      <= tick_in;
      s2      <= s1;
      s2_d    <= s2;
      expired <= '0;
      pending <= pend_nxt;
      irq     <= |pend_nxt;
      unique case (state)
        IDLE: begin
          if (tick_evt || tick_pend) begin
            state     <= SCAN;
            idx       <= '0;
            tick_pend <= tick_pend & tick_evt;
          end else if (cfg_fire) begin
            if (cfg_start) begin
              cnt[cfg_ch]    <= cfg_period;
              period[cfg_ch] <= cfg_period;
              mode[cfg_ch]   <= cfg_mode;
              active[cfg_ch] <= 1'b1;
            end else begin
              active[cfg_ch] <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (tick_evt) begin
            if (tick_pend)
              overrun <= 1'b1;
            else
              tick_pend <= 1'b1;
          end
          if (active[idx]) begin
            if (cnt[idx] == '0) begin
              expired[idx] <= 1'b1;
              if (mode[idx])
                cnt[idx] <= period[idx];
              else
                active[idx] <= 1'b0;
            end else begin
              cnt[idx] <= cnt[idx] - CNT_W'(1);
            end
          end
          if (idx == LAST) begin
            state <= IDLE;
          end else begin
            idx <= idx + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: schedule-level reference model plus
// directed scenarios with literal expectations and a random phase.
module tb_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick_in = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic              cfg_start = 1'b0;
  logic              cfg_mode = 1'b0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [NUM_CH-1:0] irq_clr = '0;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] active;
  logic              irq;
  logic              overrun;

  timer_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .irq_clr(irq_clr), .expired(expired), .pending(pending),
    .active(active), .irq(irq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a scan taken at edge s services channel c at edge s+1+c.
  int          s_start;
  bit          pq, m_ovr, m_rdy, h1, h2, h3;
  bit [NUM_CH-1:0] m_act, m_pend, m_exp, m_mode;
  int unsigned m_cnt [NUM_CH];
  int unsigned m_per [NUM_CH];
  int          pulses [NUM_CH];
  int          last_edge [NUM_CH];
  int          accepts = 0;
  bit          dut_rdy = 1'b0;

  task automatic model_reset();
    s_start = -100;
    pq = 0; m_ovr = 0; m_rdy = 1;
    h1 = 0; h2 = 0; h3 = 0;
    m_act = '0; m_pend = '0; m_exp = '0; m_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0;
      m_per[i] = 0;
    end
  endtask

  initial begin
    bit tk, busy, rdy, nb;
    int n, srv, c;
    bit [NUM_CH-1:0] setv, np;
    for (int i = 0; i < NUM_CH; i++) begin
      pulses[i] = 0;
      last_edge[i] = -1;
    end
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      n = cyc;
      if (cfg_valid && dut_rdy)
        accepts++;
      if (rst) begin
        model_reset();
      end else begin
        tk   = h2 & ~h3;
        busy = (n > s_start) && (n <= s_start + NUM_CH);
        rdy  = !busy && !tk && !pq;
        srv  = busy ? n - s_start - 1 : -1;
        if (!busy && (tk || pq)) begin
          s_start = n;
          pq = pq && tk;
        end else if (busy && tk) begin
          if (pq) m_ovr = 1;
          else pq = 1;
        end
        m_exp = '0;
        setv = '0;
        if (srv >= 0 && m_act[srv]) begin
          if (m_cnt[srv] == 0) begin
            m_exp[srv] = 1;
            setv[srv] = 1;
            if (m_mode[srv]) m_cnt[srv] = m_per[srv];
            else m_act[srv] = 0;
          end else begin
            m_cnt[srv] = m_cnt[srv] - 1;
          end
        end
        np = m_pend & ~irq_clr;
        if (cfg_valid && rdy && int'(cfg_ch) < NUM_CH) begin
          c = int'(cfg_ch);
          if (cfg_start) begin
            m_cnt[c] = cfg_period;
            m_per[c] = cfg_period;
            m_mode[c] = cfg_mode;
            m_act[c] = 1;
            np[c] = 0;
          end else begin
            m_act[c] = 0;
          end
        end
        m_pend = np | setv;
        h3 = h2; h2 = h1; h1 = tick_in;
        nb = (n + 1 > s_start) && (n + 1 <= s_start + NUM_CH);
        m_rdy = !nb && !(h2 & ~h3) && !pq;
      end
      #1;
      chk("expired", 32'(expired), 32'(m_exp));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("active", 32'(active), 32'(m_act));
      chk("irq", 32'(irq), 32'(|m_pend));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
      dut_rdy = cfg_ready;
      for (int i = 0; i < NUM_CH; i++)
        if (expired[i]) begin
          pulses[i]++;
          last_edge[i] = cyc;
        end
    end
  end

  task automatic do_rst();
    rst = 1; tick_in = 0; cfg_valid = 0; irq_clr = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input bit st, input bit md, input int p);
    bit done = 0;
    cfg_ch = ch[CH_W-1:0];
    cfg_start = st;
    cfg_mode = md;
    cfg_period = p[CNT_W-1:0];
    cfg_valid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cfg_ready) done = 1;
      @(negedge clk);
    end
    cfg_valid = 0;
    if (!done) begin
      errors++;
      $display("FAIL cfg_timeout ch %0d: got no ready, expected ready within 200 cycles", ch);
    end
  endtask

  task automatic tick_pulse(input int hi, input int lo, output int k);
    tick_in = 1;
    k = cyc + 1;
    repeat (hi) @(negedge clk);
    tick_in = 0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int k, b, a;
    repeat (3) @(negedge clk);
    do_rst();

    // periodic P=2: expiry every third tick
    cfg(0, 1, 1, 2);
    b = pulses[0];
    for (int i = 1; i <= 9; i++) begin
      tick_pulse(3, 17, k);
      chk("periodic_count", 32'(pulses[0] - b), 32'(i / 3));
    end
    chk("periodic_active", 32'(active[0]), 32'd1);

    // one-shot P=0
    do_rst();
    cfg(1, 1, 0, 0);
    b = pulses[1];
    repeat (3) tick_pulse(3, 17, k);
    chk("oneshot_count", 32'(pulses[1] - b), 32'd1);
    chk("oneshot_active", 32'(active[1]), 32'd0);
    chk("oneshot_pending", 32'(pending[1]), 32'd1);
    chk("oneshot_irq", 32'(irq), 32'd1);
    irq_clr = 4'b0010;
    @(negedge clk);
    irq_clr = '0;
    chk("clr_pending", 32'(pending[1]), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // all channels P=0: consecutive service edges k+3..k+6
    do_rst();
    for (int c = 0; c < NUM_CH; c++) cfg(c, 1, 1, 0);
    tick_pulse(3, 20, k);
    for (int c = 0; c < NUM_CH; c++)
      chk("scan_edge", 32'(last_edge[c]), 32'(k + 3 + c));

    // config held during scan, ticks 2 clk apart
    do_rst();
    a = accepts;
    fork
      begin
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
          tick_in = 1;
          @(negedge clk);
          tick_in = 0;
          @(negedge clk);
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk("ready_in_scan", 32'(cfg_ready), 32'd0);
        cfg(2, 1, 1, 3);
      end
    join
    repeat (5) @(negedge clk);
    chk("accept_once", 32'(accepts - a), 32'd1);
    chk("held_cfg_active", 32'(active[2]), 32'd1);
    chk("overrun_set", 32'(overrun), 32'd1);

    // irq_clr on the expiry edge
    do_rst();
    cfg(0, 1, 1, 0);
    b = pulses[0];
    tick_in = 1;
    k = cyc + 1;
    repeat (3) @(negedge clk);
    tick_in = 0;
    irq_clr = 4'b0001;
    @(negedge clk);
    irq_clr = '0;
    chk("set_wins_pulse", 32'(pulses[0] - b), 32'd1);
    chk("set_wins_pending", 32'(pending[0]), 32'd1);

    // reset mid-scan before ch2 expires
    do_rst();
    cfg(2, 1, 0, 0);
    b = pulses[2];
    tick_in = 1;
    k = cyc + 1;
    repeat (3) @(negedge clk);
    tick_in = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_no_pulse", 32'(pulses[2] - b), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    repeat (10) @(negedge clk);
    chk("rst_still_no_pulse", 32'(pulses[2] - b), 32'd0);

    // random phase
    do_rst();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) tick_in = ~tick_in;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_start = ($urandom_range(0, 4) != 0);
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_period = CNT_W'($urandom_range(0, 4));
      irq_clr = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 0;
    cfg_valid = 0;
    irq_clr = '0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
